// File: rtl/boot_copy_ctrl.sv
`timescale 1ns/1ps
// Boot copy sequencer: copies the model-specific Z80 boot image from the boot ROM
// into main RAM while holding the CPU in reset, then releases the CPU.
module boot_copy_ctrl #(
    parameter int          LENGTH    = 275,
    parameter logic [15:0] DEST_BASE = 16'h0000,
    parameter int          ROM_AW    = 9
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              model,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_model,
    input  logic [7:0]        rom_data,
    output logic [15:0]       ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic              ram_ack,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(LENGTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ROM_AW-1:0] idx;
    logic              accept;
    logic              load_byte;
    logic              byte_acked;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        load_byte  = 1'b0;
        byte_acked = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_reset  = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                load_byte = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy = 1'b1;
                if (ram_ack) begin
                    byte_acked = 1'b1;
                    state_nxt  = (idx == LAST_IDX) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write request is registered at the LOAD edge and held untouched until the acking edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            rom_model <= 1'b0;
            ram_addr  <= DEST_BASE;
            ram_wdata <= 8'h00;
            ram_we    <= 1'b0;
        end else begin
            if (accept) begin
                idx       <= '0;
                rom_model <= model;
            end
            if (load_byte) begin
                ram_addr  <= DEST_BASE + 16'(idx);
                ram_wdata <= rom_data;
                ram_we    <= 1'b1;
            end
            if (byte_acked) begin
                ram_we <= 1'b0;
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign rom_addr = idx;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for boot_copy_ctrl: a behavioural boot ROM feeds the DUT, expected
// RAM writes are queued at each start and popped as the DUT's writes are acknowledged.
module tb_boot_copy_ctrl;

    localparam int          LENGTH    = 275;
    localparam logic [15:0] DEST_BASE = 16'h0000;
    localparam int          ROM_AW    = 9;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic              model   = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_model;
    logic [7:0]        rom_data;
    logic [15:0]       ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic              ram_ack = 1'b0;
    logic              cpu_reset;
    logic              busy;
    logic              done;

    boot_copy_ctrl #(
        .LENGTH   (LENGTH),
        .DEST_BASE(DEST_BASE),
        .ROM_AW   (ROM_AW)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .start    (start),
        .model    (model),
        .rom_addr (rom_addr),
        .rom_model(rom_model),
        .rom_data (rom_data),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_ack  (ram_ack),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         mon_off;
    int         vectors     = 0;
    int         miscompares = 0;
    int         writes_seen = 0;
    int         ack_mode    = 0;
    int         stall_left  = 0;
    logic [7:0] img    [0:LENGTH-1];
    logic [7:0] img_m0 [0:LENGTH-1];

    logic        prev_we = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    // Boot ROM contents: the model-dependent bytes at 0x2E and 0x80, fixed jumps elsewhere.
    function automatic logic [7:0] boot_byte(input int i, input logic m);
        case (i)
            0:      return 8'hC3;
            'h2E:   return m ? 8'h20 : 8'h21;
            'h80:   return m ? 8'h3D : 8'h3C;
            'h110:  return 8'hC3;
            default: return 8'((i * 37 + 11) ^ (i >> 2));
        endcase
    endfunction

    always_comb rom_data = boot_byte(int'(rom_addr), rom_model);

    function automatic int image_errors(input logic m);
        int bad = 0;
        for (int i = 0; i < LENGTH; i++) begin
            if (img[i] !== boot_byte(i, m)) bad++;
        end
        return bad;
    endfunction

    // Ack driver: tied high, or random 0..7 cycle stalls between acks.
    always @(posedge clk_sys) begin
        #1;
        if (ack_mode == 0) begin
            ram_ack = 1'b1;
        end else if (stall_left > 0) begin
            ram_ack = 1'b0;
            stall_left--;
        end else begin
            ram_ack = 1'b1;
            stall_left = $urandom_range(0, 7);
        end
    end

    // Write monitor: scoreboard pop on every consuming edge, stability check across stalls.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_we = 1'b0;
        end else begin
            if (prev_we && !prev_ack) begin
                vectors++;
                if (ram_we !== 1'b1 || ram_addr !== prev_addr || ram_wdata !== prev_data) begin
                    miscompares++;
                    $display("FAIL stall_hold: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                             ram_we, ram_addr, ram_wdata, prev_addr, prev_data);
                end
            end
            if (ram_we === 1'b1 && ram_ack === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write", ram_addr, ram_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data) begin
                        miscompares++;
                        $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                                 ram_addr, ram_wdata, mon_e.addr, mon_e.data);
                    end
                end
                mon_off = int'(ram_addr - DEST_BASE);
                if (mon_off < LENGTH) img[mon_off] = ram_wdata;
                writes_seen++;
            end
            prev_we   = ram_we;
            prev_ack  = ram_ack;
            prev_addr = ram_addr;
            prev_data = ram_wdata;
        end
    end

    task automatic start_copy(input logic m);
        wr_t e;
        model       = m;
        start       = 1'b1;
        writes_seen = 0;
        exp_q.delete();
        for (int i = 0; i < LENGTH; i++) begin
            img[i] = 8'hxx;
            e.addr = DEST_BASE + 16'(i);
            e.data = boot_byte(i, m);
            exp_q.push_back(e);
        end
        @(posedge clk_sys);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, input int limit);
        cycles = 0;
        while (cycles < limit) begin
            @(posedge clk_sys);
            #1;
            cycles++;
            if (done === 1'b1) return;
        end
    endtask

    task automatic wait_writes(input int n, input string tag);
        int c = 0;
        while (writes_seen < n && c < 4000) begin
            @(posedge clk_sys);
            #1;
            c++;
        end
        vectors++;
        if (writes_seen < n) begin
            miscompares++;
            $display("FAIL %s_progress: writes=%0d, required >=%0d", tag, writes_seen, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        vectors++;
        if ({cpu_reset, busy, done, ram_we, rom_model} !== 5'b10000 || ram_addr !== DEST_BASE ||
            ram_wdata !== 8'h00 || rom_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_values: rst/busy/done/we/model=%b addr=%h data=%h rom_addr=%h, required 10000 %h 00 000",
                     {cpu_reset, busy, done, ram_we, rom_model}, ram_addr, ram_wdata, rom_addr, DEST_BASE);
        end
        #19;
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        vectors++;
        if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: rst/busy/done=%b%b%b, required 100", cpu_reset, busy, done);
        end
    endtask

    task automatic test_cold_boot_m0();
        int cyc;
        ack_mode = 0;
        start_copy(1'b0);
        vectors++;
        if (busy !== 1'b1 || cpu_reset !== 1'b1 || ram_we !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_n1: busy/rst/we/done=%b%b%b%b, required 1100", busy, cpu_reset, ram_we, done);
        end
        @(posedge clk_sys);
        #1;
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== DEST_BASE || ram_wdata !== 8'hC3) begin
            miscompares++;
            $display("FAIL first_write: we=%b addr=%h data=%h, required 1 %h c3", ram_we, ram_addr, ram_wdata, DEST_BASE);
        end
        wait_done(cyc, 1000);
        vectors++;
        if (done !== 1'b1 || cyc != 549) begin
            miscompares++;
            $display("FAIL done_latency: done=%b after %0d edges past N+1, required 1 after 549", done, cyc);
        end
        vectors++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL released: cpu_reset=%b busy=%b, required 0 0", cpu_reset, busy);
        end
        vectors++;
        if (image_errors(1'b0) != 0 || writes_seen != LENGTH || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL image_m0: bad=%0d writes=%0d left=%0d, required 0 %0d 0",
                     image_errors(1'b0), writes_seen, exp_q.size(), LENGTH);
        end
        vectors++;
        if (img[0] !== 8'hC3 || img['h2E] !== 8'h21 || img['h80] !== 8'h3C || img['h110] !== 8'hC3) begin
            miscompares++;
            $display("FAIL key_bytes_m0: %h %h %h %h, required c3 21 3c c3", img[0], img['h2E], img['h80], img['h110]);
        end
        for (int i = 0; i < LENGTH; i++) img_m0[i] = img[i];
    endtask

    // Restart from DONE with model 1, with a start pulse coinciding with the final ack.
    task automatic test_model1_from_done();
        int diff = 0;
        ack_mode = 0;
        start_copy(1'b1);
        vectors++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || rom_model !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_from_done: rst/done/busy/model=%b%b%b%b, required 1011",
                     cpu_reset, done, busy, rom_model);
        end
        for (int c = 1; c <= 551; c++) begin
            @(posedge clk_sys);
            #1;
            if (c == 549) begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_done: done=%b at edge N+549, required 0", done);
                end
                start = 1'b1;
            end else if (c == 550) begin
                start = 1'b0;
                vectors++;
                if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_m1: done/rst/busy=%b%b%b at N+550, required 100", done, cpu_reset, busy);
                end
            end else if (c == 551) begin
                vectors++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL start_at_final_ack: done=%b busy=%b, required 1 0", done, busy);
                end
            end
        end
        vectors++;
        if (image_errors(1'b1) != 0 || writes_seen != LENGTH || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL image_m1: bad=%0d writes=%0d left=%0d, required 0 %0d 0",
                     image_errors(1'b1), writes_seen, exp_q.size(), LENGTH);
        end
        for (int i = 0; i < LENGTH; i++) begin
            if (i != 'h2E && i != 'h80 && img[i] !== img_m0[i]) diff++;
        end
        vectors++;
        if (img['h2E] !== 8'h20 || img['h80] !== 8'h3D || diff != 0) begin
            miscompares++;
            $display("FAIL m1_vs_m0: 2E=%h 80=%h other_diffs=%0d, required 20 3d 0", img['h2E], img['h80], diff);
        end
    endtask

    task automatic test_stalls();
        int cyc;
        ack_mode   = 1;
        stall_left = 0;
        start_copy(1'b0);
        wait_done(cyc, 6000);
        vectors++;
        if (done !== 1'b1 || image_errors(1'b0) != 0 || writes_seen != LENGTH || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_image: done=%b bad=%0d writes=%0d left=%0d, required 1 0 %0d 0",
                     done, image_errors(1'b0), writes_seen, exp_q.size(), LENGTH);
        end
    endtask

    task automatic test_midcopy_start();
        int cyc;
        ack_mode = 1;
        start_copy(1'b0);
        wait_writes(50, "midcopy");
        model = 1'b1;
        start = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || rom_model !== 1'b0) begin
            miscompares++;
            $display("FAIL midcopy_ignore: busy=%b rom_model=%b, required 1 0", busy, rom_model);
        end
        wait_done(cyc, 6000);
        vectors++;
        if (done !== 1'b1 || image_errors(1'b0) != 0 || writes_seen != LENGTH || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midcopy_image: done=%b bad=%0d writes=%0d left=%0d, required 1 0 %0d 0",
                     done, image_errors(1'b0), writes_seen, exp_q.size(), LENGTH);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        ack_mode = 1;
        start_copy(1'b1);
        wait_writes(100, "abort");
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({cpu_reset, busy, done, ram_we, rom_model} !== 5'b10000 || ram_addr !== DEST_BASE ||
            ram_wdata !== 8'h00 || rom_addr !== '0) begin
            miscompares++;
            $display("FAIL abort_values: rst/busy/done/we/model=%b addr=%h data=%h rom_addr=%h, required 10000 %h 00 000",
                     {cpu_reset, busy, done, ram_we, rom_model}, ram_addr, ram_wdata, rom_addr, DEST_BASE);
        end
        exp_q.delete();
        repeat (2) @(posedge clk_sys);
        #3;
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        start_copy(1'b1);
        wait_done(cyc, 6000);
        vectors++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || image_errors(1'b1) != 0 || writes_seen != LENGTH ||
            exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_restart: done=%b rst=%b bad=%0d writes=%0d left=%0d, required 1 0 0 %0d 0",
                     done, cpu_reset, image_errors(1'b1), writes_seen, exp_q.size(), LENGTH);
        end
    endtask

    initial begin
        test_reset();
        test_cold_boot_m0();
        test_model1_from_done();
        test_stalls();
        test_midcopy_start();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
